latch_bank_writer: RTL and testbench

//  Initiator side of the gated-D-latch interface. Accepts write requests over a valid/ready

---
 rtl/latch_bank_writer.sv | 136 +++++++++++++
 tb/tb_latch_bank_writer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/latch_bank_writer.sv
// latch_bank_writer
//   Initiator for a bank of gated D latches. A write request is accepted over a
//   valid/ready handshake, then the shared data bus and a one-hot enable are
//   sequenced so each latch sees a guaranteed setup, pulse width and hold,
//   all measured in clock cycles.
//
// Parameters
//   DATA_W     latch word width / lat_d width
//   ADDR_W     latch select width (bank holds 2**ADDR_W words)
//   SETUP_CYC  cycles lat_d is stable before the enable rises (>=1)
//   PULSE_CYC  cycles the selected enable is held high (>=1)
//   HOLD_CYC   cycles lat_d is held after the enable falls (>=1)
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   wr_valid  in   write request valid
//   wr_ready  out  request can be accepted (high only in IDLE)
//   wr_addr   in   target latch index, sampled on accept
//   wr_data   in   data word, sampled on accept
//   lat_d     out  shared D bus to all latches
//   lat_en    out  one-hot latch enables
//   busy      out  transaction in progress
//   done      out  one-cycle pulse on return to IDLE
module latch_bank_writer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  output logic [DATA_W-1:0]      lat_d,
  output logic [(2**ADDR_W)-1:0] lat_en,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned NUM_LAT = 2**ADDR_W;
  localparam int unsigned MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [ADDR_W-1:0]  addr_q, addr_n;
  logic [DATA_W-1:0]  d_n;
  logic [NUM_LAT-1:0] en_n;
  logic               ready_n, busy_n, done_n;

  // The counter holds "cycles remaining minus one" in the current state, so a
  // state is left on the edge where it reads zero.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr_q;
    d_n     = lat_d;
    en_n    = lat_en;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_valid && wr_ready) begin
          addr_n  = wr_addr;
          d_n     = wr_data;
          cnt_n   = CNT_W'(SETUP_CYC - 1);
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          en_n    = NUM_LAT'(1) << addr_q;
          cnt_n   = CNT_W'(PULSE_CYC - 1);
          state_n = PULSE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          en_n    = '0;
          cnt_n   = CNT_W'(HOLD_CYC - 1);
          state_n = HOLD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Handshake outputs are registered copies of the next state.
    ready_n = (state_n == IDLE);
    busy_n  = !ready_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      lat_d    <= '0;
      lat_en   <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      wr_ready <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      addr_q   <= addr_n;
      lat_d    <= d_n;
      lat_en   <= en_n;
      done     <= done_n;
      busy     <= busy_n;
      wr_ready <= ready_n;
    end
  end

endmodule

// File: tb/tb_latch_bank_writer.sv
module tb_latch_bank_writer;

  logic       clk = 1'b0;
  logic       rst, wr_valid, wr_ready, busy, done;
  logic [1:0] wr_addr;
  logic [7:0] wr_data, lat_d;
  logic [3:0] lat_en;

  logic       rst6, valid6, ready6, busy6, done6;
  logic [1:0] addr6;
  logic [7:0] data6, d6;
  logic [3:0] en6;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem [4];

  always #5 clk = ~clk;

  latch_bank_writer #(.DATA_W(8), .ADDR_W(2), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .lat_d(lat_d), .lat_en(lat_en),
    .busy(busy), .done(done)
  );

  latch_bank_writer #(.DATA_W(8), .ADDR_W(2), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) dut6 (
    .clk(clk), .rst(rst6), .wr_valid(valid6), .wr_ready(ready6),
    .wr_addr(addr6), .wr_data(data6), .lat_d(d6), .lat_en(en6),
    .busy(busy6), .done(done6)
  );

  // Behavioural gated D latch bank: transparent while its enable is high.
  always @(lat_en or lat_d) begin
    for (int i = 0; i < 4; i++)
      if (lat_en[i]) mem[i] = lat_d;
  end

  typedef struct {
    logic       rst;
    logic       valid;
    logic [1:0] addr;
    logic [7:0] data;
    logic [7:0] d;
    logic [3:0] en;
    logic       busy;
    logic       done;
    logic       ready;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check(name, int'(done), 1);
  endtask

  initial begin
    int acc2, done_at;
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rst6 = 1'b1; valid6 = 1'b0; addr6 = '0; data6 = '0;

    //            rst  vld addr data    lat_d  en       busy done ready
    tbl[0] = '{1'b1, 1'b1, 2'd1, 8'hFF, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b1}; // reset, request ignored
    tbl[1] = '{1'b1, 1'b1, 2'd1, 8'hFF, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 2'd2, 8'hA5, 8'hA5, 4'b0000, 1'b1, 1'b0, 1'b0}; // edge 0: accept
    tbl[3] = '{1'b0, 1'b0, 2'd2, 8'hA5, 8'hA5, 4'b0100, 1'b1, 1'b0, 1'b0}; // edge 1
    tbl[4] = '{1'b0, 1'b1, 2'd0, 8'h33, 8'hA5, 4'b0100, 1'b1, 1'b0, 1'b0}; // edge 2, busy request ignored
    tbl[5] = '{1'b0, 1'b0, 2'd1, 8'h44, 8'hA5, 4'b0000, 1'b1, 1'b0, 1'b0}; // edge 3
    tbl[6] = '{1'b0, 1'b1, 2'd3, 8'h55, 8'hA5, 4'b0000, 1'b0, 1'b1, 1'b1}; // edge 4: done
    tbl[7] = '{1'b0, 1'b0, 2'd3, 8'h55, 8'hA5, 4'b0000, 1'b0, 1'b0, 1'b1}; // idle holds lat_d
    tbl[8] = '{1'b0, 1'b0, 2'd0, 8'h00, 8'hA5, 4'b0000, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; wr_valid = tbl[i].valid;
      wr_addr = tbl[i].addr; wr_data = tbl[i].data;
      tick();
      check($sformatf("v%0d_lat_d", i), int'(lat_d), int'(tbl[i].d));
      check($sformatf("v%0d_lat_en", i), int'(lat_en), int'(tbl[i].en));
      check($sformatf("v%0d_busy", i), int'(busy), int'(tbl[i].busy));
      check($sformatf("v%0d_done", i), int'(done), int'(tbl[i].done));
      check($sformatf("v%0d_ready", i), int'(wr_ready), int'(tbl[i].ready));
    end
    check("single_mem2", int'(mem[2]), 8'hA5);

    // Back-to-back with wr_valid held high.
    wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 8'h11;
    tick();
    check("b2b_first_d", int'(lat_d), 8'h11);
    wr_addr = 2'd3; wr_data = 8'hEE;
    acc2 = -1; done_at = -1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check("b2b_onehot", int'($countones(lat_en) <= 1), 1);
      if (lat_en[0]) check("b2b_d_during_en0", int'(lat_d), 8'h11);
      if (done && done_at < 0) done_at = e;
      if (lat_d == 8'hEE && acc2 < 0) begin
        acc2 = e;
        wr_valid = 1'b0;
      end
    end
    check("b2b_done_edge", done_at, 4);
    check("b2b_accept2_edge", acc2, 5);
    wait_done("b2b_done2");
    check("b2b_mem0", int'(mem[0]), 8'h11);
    check("b2b_mem3", int'(mem[3]), 8'hEE);
    tick();

    // Reset in the middle of PULSE.
    wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 8'h5A;
    tick();
    wr_valid = 1'b0;
    tick();
    check("rp_en_pulse", int'(lat_en), 4'b0010);
    rst = 1'b1;
    tick();
    check("rp_en", int'(lat_en), 0);
    check("rp_d", int'(lat_d), 0);
    check("rp_done", int'(done), 0);
    check("rp_ready", int'(wr_ready), 1);
    check("rp_busy", int'(busy), 0);
    rst = 1'b0;
    for (int e = 0; e < 4; e++) begin
      tick();
      check("rp_no_done", int'(done), 0);
    end
    wr_valid = 1'b1; wr_addr = 2'd3; wr_data = 8'h77;
    tick();
    wr_valid = 1'b0;
    wait_done("rp_next_done");
    check("rp_next_mem3", int'(mem[3]), 8'h77);
    check("rp_next_d", int'(lat_d), 8'h77);

    // SETUP=3 PULSE=1 HOLD=2 instance.
    tick();
    tick();
    rst6 = 1'b0; valid6 = 1'b1; addr6 = 2'd1; data6 = 8'hC3;
    tick();
    valid6 = 1'b0; data6 = 8'h00;
    check("p6_d", int'(d6), 8'hC3);
    check("p6_en0", int'(en6), 0);
    check("p6_ready0", int'(ready6), 0);
    for (int e = 1; e <= 6; e++) begin
      tick();
      check($sformatf("p6_en_e%0d", e), int'(en6), (e == 3) ? 2 : 0);
      check($sformatf("p6_ready_e%0d", e), int'(ready6), (e == 6) ? 1 : 0);
      check($sformatf("p6_done_e%0d", e), int'(done6), (e == 6) ? 1 : 0);
    end
    check("p6_d_hold", int'(d6), 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
